// File: rtl/pcm_mic_capture_ctrl.sv
// PDM microphone capture sequencer: divides clk into mic_clk, samples one PDM bit per period,
// boxcar-decimates DECIM bits into a PCM word and writes the words sequentially into the sample RAM.
//
// state  | meaning
// IDLE   | after reset, waiting for start
// RECORD | mic_clk running, words being written
// DONE   | stopped or RAM full, wr_addr frozen, waiting for start
module pcm_mic_capture_ctrl #(
  parameter int DIV_HALF = 20,
  parameter int DECIM    = 64,
  parameter int SAMPLE_W = 8,
  parameter int ADDR_W   = 15
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic                stop,
  input  logic                mic_data,
  output logic                mic_clk,
  output logic                mic_lr,
  output logic                wr_en,
  output logic [ADDR_W-1:0]   wr_addr,
  output logic [SAMPLE_W-1:0] wr_data,
  output logic                busy,
  output logic                done,
  output logic                led
);

  localparam int DW = (DIV_HALF > 1) ? $clog2(DIV_HALF) : 1;
  localparam int BW = (DECIM > 1) ? $clog2(DECIM) : 1;
  localparam logic [DW-1:0]     DIV_LAST  = DW'(DIV_HALF - 1);
  localparam logic [BW-1:0]     BIT_LAST  = BW'(DECIM - 1);
  localparam logic [ADDR_W-1:0] ADDR_LAST = '1;

  typedef enum logic [1:0] {IDLE, RECORD, DONE} state_t;

  state_t              state, next_state;
  logic [DW-1:0]       div_cnt;
  logic [BW-1:0]       bit_cnt;
  logic [SAMPLE_W-1:0] acc;
  logic [SAMPLE_W-1:0] acc_next;

  assign acc_next = acc + SAMPLE_W'(mic_data);
  assign mic_lr   = 1'b0;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE, DONE: if (start && !stop) next_state = RECORD;
      RECORD:     if (stop || (wr_en && wr_addr == ADDR_LAST)) next_state = DONE;
      default:    next_state = IDLE;
    endcase
  end

  always_comb begin
    busy = (state == RECORD);
    done = (state == DONE);
    led  = busy;
  end

  // Datapath keys off next_state so that leaving RECORD (stop or full) drops the partial word
  // and returns mic_clk to 0 in the very first DONE cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      div_cnt <= DIV_LAST;
      mic_clk <= 1'b0;
      acc     <= '0;
      bit_cnt <= '0;
      wr_en   <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
    end else begin
      wr_en <= 1'b0;
      if (wr_en && wr_addr != ADDR_LAST) wr_addr <= wr_addr + 1'b1;
      if (state != RECORD && next_state == RECORD) begin
        div_cnt <= DIV_LAST;
        mic_clk <= 1'b0;
        acc     <= '0;
        bit_cnt <= '0;
        wr_addr <= '0;
      end else if (state == RECORD && next_state == RECORD) begin
        if (div_cnt == '0) begin
          div_cnt <= DIV_LAST;
          mic_clk <= ~mic_clk;
          if (mic_clk) begin
            if (bit_cnt == BIT_LAST) begin
              wr_data <= acc_next;
              wr_en   <= 1'b1;
              acc     <= '0;
              bit_cnt <= '0;
            end else begin
              acc     <= acc_next;
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
        end else begin
          div_cnt <= div_cnt - 1'b1;
        end
      end else begin
        div_cnt <= DIV_LAST;
        mic_clk <= 1'b0;
        acc     <= '0;
        bit_cnt <= '0;
      end
    end
  end

endmodule

// File: tb/tb_pcm_mic_capture_ctrl.sv
// Bench for pcm_mic_capture_ctrl: a time-based model of the recording checked every cycle,
// plus directed scenarios with literal expectations.
module tb_pcm_mic_capture_ctrl;
  localparam int DH = 2, DEC = 4, SW = 3, AW = 3;
  localparam int P = 2 * DH * DEC;
  localparam int LAST = (1 << AW) - 1;

  logic clk = 0, reset = 1, start = 0, stop = 0, mic_data = 0;
  logic mic_clk, mic_lr, wr_en, busy, done, led;
  logic [AW-1:0] wr_addr;
  logic [SW-1:0] wr_data;

  pcm_mic_capture_ctrl #(.DIV_HALF(DH), .DECIM(DEC), .SAMPLE_W(SW), .ADDR_W(AW)) dut (
    .clk(clk), .reset(reset), .start(start), .stop(stop), .mic_data(mic_data),
    .mic_clk(mic_clk), .mic_lr(mic_lr), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .busy(busy), .done(done), .led(led));

  always #5 clk = ~clk;

  int checks = 0, failures = 0;
  int cyc = 0, s_ref = 0, wr_cnt = 0;
  logic [3:0] pat = 4'b1111;

  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (wr_en === 1'b1) wr_cnt++;
  // Bit b of each word (sampled at record cycle 4b+3) comes from pat[b].
  always @(negedge clk) mic_data = pat[((cyc - s_ref - 1) / (2 * DH)) % DEC];

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d at cycle %0d", nm, act, exp, cyc);
    end
  endtask

  // ---------------- model: state plus time since entering RECORD ----------------
  int m_st = 0, m_t = 0, m_data = 0, m_frz = 0, ones = 0, nb = 0;
  bit m_valid = 0;

  function automatic int addr_at(int t);
    return (t == 0) ? 0 : (t - 1) / P;
  endfunction
  function automatic bit wen_at(int t);
    return (t > 0) && (t % P == 0);
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      m_st = 0; m_t = 0; m_data = 0; m_frz = 0; ones = 0; nb = 0; m_valid = 1;
    end else if (m_st == 1) begin
      if (stop || (wen_at(m_t) && addr_at(m_t) == LAST)) begin
        m_frz = (addr_at(m_t + 1) > LAST) ? LAST : addr_at(m_t + 1);
        m_st  = 2;
      end else begin
        if (m_t % (2 * DH) == 2 * DH - 1) begin
          ones += int'(mic_data); nb++;
          if (nb == DEC) begin m_data = ones; ones = 0; nb = 0; end
        end
        m_t++;
      end
    end else if (start && !stop) begin
      m_st = 1; m_t = 0; ones = 0; nb = 0;
    end
  end

  always @(negedge clk) if (m_valid) begin
    bit rec;
    rec = (m_st == 1);
    chk("mic_clk", mic_clk, rec ? (m_t / DH) % 2 : 0);
    chk("mic_lr",  mic_lr,  0);
    chk("wr_en",   wr_en,   rec ? wen_at(m_t) : 0);
    chk("wr_addr", wr_addr, rec ? addr_at(m_t) : m_frz);
    chk("wr_data", wr_data, m_data);
    chk("busy",    busy,    rec);
    chk("done",    done,    m_st == 2);
    chk("led",     led,     rec);
  end

  // ---------------- directed stimulus ----------------
  task automatic step(int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_start();
    s_ref = cyc; start = 1; step(); start = 0;
  endtask

  task automatic wait_wr(string nm, output int rt);
    int n = 0;
    do begin @(negedge clk); n++; end while (wr_en !== 1'b1 && n < 40);
    rt = cyc - s_ref - 1;
    if (wr_en !== 1'b1) begin
      failures++; checks++;
      $display("FAIL %s_timeout actual=no_wr_en required=wr_en within 40 cycles", nm);
    end
  endtask

  int rt, cnt0;
  int exp_data[8] = '{4, 4, 2, 3, 0, 0, 0, 0};
  logic [3:0] pats[8] = '{4'b1111, 4'b1111, 4'b0101, 4'b0111, 4'b0000, 4'b0000, 4'b0000, 4'b0000};

  initial begin
    step(3);
    reset = 0;
    chk("reset_busy", busy, 0);
    chk("reset_addr", wr_addr, 0);

    // full run: constant 1, alternating, three ones, zeros; start held mid-record is ignored
    pat = pats[0];
    do_start();
    for (int w = 0; w < 8; w++) begin
      wait_wr("full", rt);
      chk("full_time", rt, P * (w + 1));
      chk("full_addr", wr_addr, w);
      chk("full_data", wr_data, exp_data[w]);
      if (w < 7) pat = pats[w + 1];
      if (w == 2) start = 1;
      if (w == 3) start = 0;
    end
    step();
    chk("full_done", done, 1);
    chk("full_busy", busy, 0);
    chk("full_mclk", mic_clk, 0);
    chk("full_addr_hold", wr_addr, LAST);
    cnt0 = wr_cnt;
    step(40);
    chk("full_no_9th", wr_cnt, cnt0);

    // stop after two words plus two bits, then restart from address 0
    pat = 4'b1111;
    do_start();
    wait_wr("stop_w0", rt);
    wait_wr("stop_w1", rt);
    chk("stop_w1_time", rt, 2 * P);
    step(8);
    stop = 1; step(); stop = 0;
    chk("stop_done", done, 1);
    chk("stop_addr", wr_addr, 2);
    cnt0 = wr_cnt;
    step(40);
    chk("stop_no_wr", wr_cnt, cnt0);
    chk("stop_addr_frozen", wr_addr, 2);
    do_start();
    wait_wr("restart", rt);
    chk("restart_time", rt, P);
    chk("restart_addr", wr_addr, 0);
    chk("restart_data", wr_data, 4);

    // reset held three cycles mid-record
    step(5);
    reset = 1; step();
    chk("rst_busy", busy, 0);
    chk("rst_addr", wr_addr, 0);
    chk("rst_data", wr_data, 0);
    chk("rst_mclk", mic_clk, 0);
    step(2); reset = 0;
    cnt0 = wr_cnt;
    step(40);
    chk("rst_no_wr", wr_cnt, cnt0);

    // start and stop together in IDLE
    start = 1; stop = 1; step(); start = 0; stop = 0;
    chk("ss_busy", busy, 0);
    cnt0 = wr_cnt;
    step(20);
    chk("ss_idle", busy | done, 0);
    chk("ss_no_wr", wr_cnt, cnt0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end
endmodule
